md_unit: RTL



---
 rtl/md_unit_pkg.sv | 18 +
 rtl/md_unit_if.sv | 26 ++
 rtl/md_unit_iter_core.sv | 97 +++++++++
 rtl/md_unit.sv | 94 +++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared funct codes for the multiply/divide unit and its FSM state encoding.
// Funct values match the ALU funct bus produced by ID decode.
package md_unit_pkg;

    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/md_unit_if.sv
// EX-stage bundle between the pipeline and the multiply/divide unit.
// master = pipeline side, slave = md_unit.
interface md_unit_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int FUNCT_WIDTH = 6
);
    logic                   flush;
    logic                   en;
    logic [FUNCT_WIDTH-1:0] funct;
    logic [DATA_WIDTH-1:0]  operand_a;
    logic [DATA_WIDTH-1:0]  operand_b;
    logic                   stall_req;
    logic                   done;
    logic [DATA_WIDTH-1:0]  hi;
    logic [DATA_WIDTH-1:0]  lo;

    modport master (
        output flush, en, funct, operand_a, operand_b,
        input  stall_req, done, hi, lo
    );

    modport slave (
        input  flush, en, funct, operand_a, operand_b,
        output stall_req, done, hi, lo
    );
endinterface

// File: rtl/md_unit_iter_core.sv
// Iterative mul/div datapath: magnitude/sign latch, shared 2W shift register, add/sub step, counter.
// res_hi/res_lo show the sign-fixed result of the step being taken this cycle, valid when last=1.
module md_iter_core #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  step,
    input  logic                  is_div,
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] res_hi,
    output logic [DATA_WIDTH-1:0] res_lo
);
    localparam int W = DATA_WIDTH;

    logic [2*W-1:0]       acc;
    logic [2*W-1:0]       acc_nxt;
    logic [2*W-1:0]       prod;
    logic [W-1:0]         opnd;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 div_mode;
    logic                 neg_prod;
    logic                 neg_q;
    logic                 neg_r;

    logic                 sign_a;
    logic                 sign_b;
    logic [W-1:0]         mag_a;
    logic [W-1:0]         mag_b;
    logic [W:0]           sum;
    logic [W:0]           rem_sh;
    logic [W:0]           diff;
    logic                 q_bit;

    always_comb begin
        sign_a = is_signed & a[W-1];
        sign_b = is_signed & b[W-1];
        mag_a  = sign_a ? -a : a;
        mag_b  = sign_b ? -b : b;
    end

    // MUL: acc = {partial product, remaining multiplier bits}, shifts right.
    // DIV: acc = {partial remainder, remaining dividend / quotient bits}, shifts left.
    always_comb begin
        sum    = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};
        rem_sh = acc[2*W-1:W-1];
        diff   = rem_sh - {1'b0, opnd};
        q_bit  = (rem_sh >= {1'b0, opnd});
        if (div_mode) begin
            acc_nxt = {(q_bit ? diff[W-1:0] : rem_sh[W-1:0]), acc[W-2:0], q_bit};
        end else begin
            acc_nxt = {sum, acc[W-1:1]};
        end
    end

    always_comb begin
        prod = neg_prod ? -acc_nxt : acc_nxt;
        if (div_mode) begin
            res_lo = neg_q ? -acc_nxt[W-1:0]   : acc_nxt[W-1:0];
            res_hi = neg_r ? -acc_nxt[2*W-1:W] : acc_nxt[2*W-1:W];
        end else begin
            res_lo = prod[W-1:0];
            res_hi = prod[2*W-1:W];
        end
    end

    assign last = (cnt == CNT_WIDTH'(W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            opnd     <= '0;
            cnt      <= '0;
            div_mode <= 1'b0;
            neg_prod <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else if (start) begin
            div_mode <= is_div;
            opnd     <= is_div ? mag_b : mag_a;
            acc      <= {{W{1'b0}}, (is_div ? mag_a : mag_b)};
            cnt      <= '0;
            neg_prod <= sign_a ^ sign_b;
            // Divide by zero keeps the all-ones quotient; the remainder fixup restores a.
            neg_q    <= (sign_a ^ sign_b) & (b != '0);
            neg_r    <= sign_a;
        end else if (step) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/md_unit.sv
// EX-stage multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Stalls the pipeline for DATA_WIDTH+1 cycles per mul/div; flush aborts, reset discards.
module md_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int FUNCT_WIDTH = 6,
    parameter int CNT_WIDTH   = $clog2(DATA_WIDTH) + 1
) (
    input  logic     clk,
    input  logic     rst,
    md_unit_if.slave bus
);
    import md_unit_pkg::*;

    md_state_t             state;
    logic [DATA_WIDTH-1:0] hi_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic                  done_q;

    logic                  op_mul;
    logic                  op_div;
    logic                  op_signed;
    logic                  accept;
    logic                  issue;
    logic                  wr_hi;
    logic                  wr_lo;
    logic                  step;
    logic                  last;
    logic [DATA_WIDTH-1:0] res_hi;
    logic [DATA_WIDTH-1:0] res_lo;

    always_comb begin
        op_mul    = (bus.funct == FUNCT_WIDTH'(FUNCT_MULT)) || (bus.funct == FUNCT_WIDTH'(FUNCT_MULTU));
        op_div    = (bus.funct == FUNCT_WIDTH'(FUNCT_DIV))  || (bus.funct == FUNCT_WIDTH'(FUNCT_DIVU));
        op_signed = (bus.funct == FUNCT_WIDTH'(FUNCT_MULT)) || (bus.funct == FUNCT_WIDTH'(FUNCT_DIV));
        accept    = (state == ST_IDLE) && bus.en && !bus.flush;
        issue     = accept && (op_mul || op_div);
        wr_hi     = accept && (bus.funct == FUNCT_WIDTH'(FUNCT_MTHI));
        wr_lo     = accept && (bus.funct == FUNCT_WIDTH'(FUNCT_MTLO));
        step      = (state == ST_BUSY) && !bus.flush;
    end

    // Combinational so the issue cycle already holds IF/ID/EX.
    assign bus.stall_req = !rst && (issue || step);
    assign bus.done      = done_q && !bus.flush;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

    md_iter_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (issue),
        .step      (step),
        .is_div    (op_div),
        .is_signed (op_signed),
        .a         (bus.operand_a),
        .b         (bus.operand_b),
        .last      (last),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (issue) state <= ST_BUSY;
                    if (wr_hi) hi_q <= bus.operand_a;
                    if (wr_lo) lo_q <= bus.operand_a;
                end
                ST_BUSY: begin
                    if (bus.flush) begin
                        state <= ST_IDLE;
                    end else if (last) begin
                        state  <= ST_DONE;
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
